dma_ctrl: RTL and testbench
===========================

Name: dma_ctrl

Overview:
- AXI master-side sequencer for the DMA engine; consumes DMASRC/DMADST/DMALEN/DMAEN/tmp_DMAEN from the DMA slave register block.
- Copies DMALEN 32-bit words from DMASRC to DMADST as repeated read-burst/write-burst pairs through an internal burst buffer.
- Raises DMA_INTR on completion. Sits between the DMA slave registers and one AXI master port of the bus.

Parameters:
- MAX_BURST, 16, maximum beats per burst; must be ≤ 2^`AXI_LEN_BITS.
- DMA_ID, 0, value driven on ARID_M/AWID_M.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  asynchronous, active-low reset.
- DMASRC  in  32  source byte address, word aligned.
- DMADST  in  32  destination byte address, word aligned.
- DMALEN  in  32  transfer length in words.
- DMAEN  in  1  enable level.
- tmp_DMAEN  in  1  one-cycle start pulse.
- DMA_INTR  out  1  completion interrupt.
- DMA_BUSY  out  1  high while not IDLE.
- DMA_ERR  out  1  sticky error flag (see Optional Feature).
- AR channel: ARID_M out `AXI_ID_BITS, ARADDR_M out 32, ARLEN_M out `AXI_LEN_BITS, ARSIZE_M out `AXI_SIZE_BITS, ARBURST_M out 2, ARVALID_M out 1, ARREADY_M in 1.
- R channel: RID_M in, RDATA_M in 32, RRESP_M in 2, RLAST_M in 1, RVALID_M in 1, RREADY_M out 1.
- AW channel: AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M out; AWREADY_M in. Widths as on AR.
- W channel: WDATA_M out 32, WSTRB_M out `AXI_STRB_BITS, WLAST_M out 1, WVALID_M out 1, WREADY_M in 1.
- B channel: BID_M in, BRESP_M in 2, BVALID_M in 1, BREADY_M out 1.

Behaviour:
- Reset: state IDLE; all VALID/READY outputs, DMA_INTR, DMA_BUSY and DMA_ERR are 0; internal address, remaining and count registers are 0.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE:
  - On tmp_DMAEN & DMAEN: latch src=DMASRC, dst=DMADST, rem=DMALEN.
  - If rem==0, go to DONE; otherwise go to RADDR.
  - Latency: ARVALID_M is asserted the cycle after the start pulse.
- Burst size: beats = min(rem, MAX_BURST), computed at RADDR entry and held for the whole pair.
- RADDR:
  - ARVALID_M=1, ARADDR_M=src, ARLEN_M=beats-1, ARSIZE_M=3'b010, ARBURST_M=INCR (2'b01).
  - Outputs stay stable until ARREADY_M; on handshake go to RDATA.
- RDATA:
  - RREADY_M=1; each handshake writes buf[idx] and increments idx.
  - Beats beyond `beats` are dropped.
  - On handshake with RLAST_M, go to WADDR and clear idx.
- WADDR: AWVALID_M=1 with AWADDR_M=dst and the same LEN/SIZE/BURST encoding; on handshake go to WDATA.
- WDATA:
  - WVALID_M=1, WDATA_M=buf[idx], WSTRB_M=4'hF, WLAST_M=(idx==beats-1).
  - idx advances only on handshake; on the last handshake go to WRESP.
- WRESP:
  - BREADY_M=1. On BVALID_M: rem-=beats, src+=4*beats, dst+=4*beats.
  - Next state: rem==0 -> DONE; DMAEN==0 -> IDLE (abort, no interrupt); otherwise RADDR.
- DONE: DMA_INTR=1, held until DMAEN==0, then go to IDLE with DMA_INTR=0 in the following cycle.
- DMAEN dropped mid-burst: the current read/write burst pair completes (AXI is never abandoned); the stop is taken at WRESP.
- tmp_DMAEN outside IDLE: ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32. No 4KB splitting; region alignment is a software responsibility.
- Ready/valid rule: no output depends combinationally on same-cycle READY, except the handshake-driven state change.
- DMA_ERR clears on a new start.

Optional Feature:
- Macro: DMA_RESP_CHECK_EN.
- Defined: any RRESP_M or BRESP_M != OKAY sets DMA_ERR. After the current burst pair completes, go to DONE and assert DMA_INTR.
- Undefined: responses are ignored and DMA_ERR is tied to 0.

Decomposition:
- dma_pkg: state enum, BURST_INCR=2'b01, SIZE_WORD=3'b010, STRB_ALL=4'hF.
- Sub-module dma_burst_buf: MAX_BURST x 32 register array with write port (we, waddr, wdata) and async read port.

Test Plan:
- DMALEN=1, SRC=0x1000, DST=0x2000, zero-wait slave -> one AR (ARLEN=0) and one AW (AWLEN=0); data copied; DMA_INTR rises after BVALID.
- DMALEN=40 -> ARADDR 0x1000/0x1040/0x1080 with ARLEN 15/15/7; AWADDR 0x2000/0x2040/0x2080; WLAST on beats 16/16/8; memory matches.
- Random READY/VALID stalls (0-5 cycles) on all channels, DMALEN=20 -> payload unchanged; VALID outputs stable until handshake.
- DMAEN cleared mid-RDATA of the first of 3 bursts -> that burst's write completes, then IDLE; no second AR; DMA_INTR stays 0.
- DMALEN=0 start -> DONE in 1 cycle with no AXI traffic; DMA_INTR=1 until DMAEN=0. Reset asserted mid-WDATA -> all valids 0 immediately.
- With DMA_RESP_CHECK_EN, BRESP=SLVERR on the first of 2 bursts -> DMA_ERR=1, no second AR, DMA_INTR=1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and encodings for the DMA master sequencer.
// Supplies default AXI field widths when the bus build does not define them.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package dma_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WDATA = 3'd4,
      S_WRESP = 3'd5,
      S_DONE  = 3'd6
   } dma_state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [3:0] STRB_ALL   = 4'hF;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/dma_burst_buf.sv
// Burst staging buffer: one registered write port, one asynchronous read port.
module dma_burst_buf
   import dma_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/dma_ctrl.sv
// AXI master sequencer copying DMALEN words from DMASRC to DMADST in read/write burst pairs.
// Optional DMA_RESP_CHECK_EN: non-OKAY responses set DMA_ERR and finish after the current pair.
module dma_ctrl
   import dma_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int DMA_ID    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               DMASRC,
   input  logic [31:0]               DMADST,
   input  logic [31:0]               DMALEN,
   input  logic                      DMAEN,
   input  logic                      tmp_DMAEN,
   output logic                      DMA_INTR,
   output logic                      DMA_BUSY,
   output logic                      DMA_ERR,
   output logic [`AXI_ID_BITS-1:0]   ARID_M,
   output logic [31:0]               ARADDR_M,
   output logic [`AXI_LEN_BITS-1:0]  ARLEN_M,
   output logic [`AXI_SIZE_BITS-1:0] ARSIZE_M,
   output logic [1:0]                ARBURST_M,
   output logic                      ARVALID_M,
   input  logic                      ARREADY_M,
   input  logic [`AXI_ID_BITS-1:0]   RID_M,
   input  logic [31:0]               RDATA_M,
   input  logic [1:0]                RRESP_M,
   input  logic                      RLAST_M,
   input  logic                      RVALID_M,
   output logic                      RREADY_M,
   output logic [`AXI_ID_BITS-1:0]   AWID_M,
   output logic [31:0]               AWADDR_M,
   output logic [`AXI_LEN_BITS-1:0]  AWLEN_M,
   output logic [`AXI_SIZE_BITS-1:0] AWSIZE_M,
   output logic [1:0]                AWBURST_M,
   output logic                      AWVALID_M,
   input  logic                      AWREADY_M,
   output logic [31:0]               WDATA_M,
   output logic [`AXI_STRB_BITS-1:0] WSTRB_M,
   output logic                      WLAST_M,
   output logic                      WVALID_M,
   input  logic                      WREADY_M,
   input  logic [`AXI_ID_BITS-1:0]   BID_M,
   input  logic [1:0]                BRESP_M,
   input  logic                      BVALID_M,
   output logic                      BREADY_M
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

   function automatic logic [BW-1:0] burst_of(input logic [31:0] r);
      return (r > 32'(MAX_BURST)) ? MAXB : r[BW-1:0];
   endfunction

   dma_state_e    state;
   logic [31:0]   src, dst, rem;
   logic [BW-1:0] beats, idx;
   logic          arvalid, rready, awvalid, wvalid, wlast, bready, intr;
   logic [31:0]   rem_next, step;
   logic [31:0]   buf_rdata;
   logic          buf_we;
   logic          start;
   logic          err_stop;

   assign start    = tmp_DMAEN & DMAEN;
   assign rem_next = rem - 32'(beats);
   assign step     = 32'(beats) << 2;
   // Beats past the negotiated length are accepted on the bus but never stored.
   assign buf_we   = rready & RVALID_M & (idx < beats);

   dma_burst_buf #(.DEPTH(MAX_BURST), .AW(AW)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx[AW-1:0]),
      .wdata (RDATA_M),
      .raddr (idx[AW-1:0]),
      .rdata (buf_rdata)
   );

`ifdef DMA_RESP_CHECK_EN
   logic err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (state == S_IDLE && start) begin
         err <= 1'b0;
      end else if ((rready && RVALID_M && RRESP_M != RESP_OKAY) ||
                   (bready && BVALID_M && BRESP_M != RESP_OKAY)) begin
         err <= 1'b1;
      end
   end

   assign err_stop = err | (BRESP_M != RESP_OKAY);
   assign DMA_ERR  = err;
`else
   assign err_stop = 1'b0;
   assign DMA_ERR  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         src     <= '0;
         dst     <= '0;
         rem     <= '0;
         beats   <= '0;
         idx     <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         wlast   <= 1'b0;
         bready  <= 1'b0;
         intr    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  src <= DMASRC;
                  dst <= DMADST;
                  rem <= DMALEN;
                  idx <= '0;
                  if (DMALEN == 32'd0) begin
                     intr  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     beats   <= burst_of(DMALEN);
                     arvalid <= 1'b1;
                     state   <= S_RADDR;
                  end
               end
            end
            S_RADDR: begin
               if (ARREADY_M) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  idx     <= '0;
                  state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (RVALID_M) begin
                  if (idx < beats) idx <= idx + 1'b1;
                  if (RLAST_M) begin
                     rready  <= 1'b0;
                     idx     <= '0;
                     awvalid <= 1'b1;
                     state   <= S_WADDR;
                  end
               end
            end
            S_WADDR: begin
               if (AWREADY_M) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  wlast   <= (beats == BW'(1));
                  state   <= S_WDATA;
               end
            end
            S_WDATA: begin
               if (WREADY_M) begin
                  if (idx == beats - 1'b1) begin
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                     state  <= S_WRESP;
                  end else begin
                     idx   <= idx + 1'b1;
                     wlast <= (idx + BW'(2) == beats);
                  end
               end
            end
            S_WRESP: begin
               if (BVALID_M) begin
                  bready <= 1'b0;
                  rem    <= rem_next;
                  src    <= src + step;
                  dst    <= dst + step;
                  idx    <= '0;
                  // Stopping is only decided here so an open burst pair is never abandoned.
                  if (rem_next == 32'd0 || err_stop) begin
                     intr  <= 1'b1;
                     state <= S_DONE;
                  end else if (!DMAEN) begin
                     state <= S_IDLE;
                  end else begin
                     beats   <= burst_of(rem_next);
                     arvalid <= 1'b1;
                     state   <= S_RADDR;
                  end
               end
            end
            S_DONE: begin
               if (!DMAEN) begin
                  intr  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign DMA_INTR  = intr;
   assign DMA_BUSY  = (state != S_IDLE);

   assign ARID_M    = `AXI_ID_BITS'(DMA_ID);
   assign ARADDR_M  = src;
   assign ARLEN_M   = `AXI_LEN_BITS'(beats - 1'b1);
   assign ARSIZE_M  = `AXI_SIZE_BITS'(SIZE_WORD);
   assign ARBURST_M = BURST_INCR;
   assign ARVALID_M = arvalid;
   assign RREADY_M  = rready;

   assign AWID_M    = `AXI_ID_BITS'(DMA_ID);
   assign AWADDR_M  = dst;
   assign AWLEN_M   = `AXI_LEN_BITS'(beats - 1'b1);
   assign AWSIZE_M  = `AXI_SIZE_BITS'(SIZE_WORD);
   assign AWBURST_M = BURST_INCR;
   assign AWVALID_M = awvalid;

   assign WDATA_M   = buf_rdata;
   assign WSTRB_M   = `AXI_STRB_BITS'(STRB_ALL);
   assign WLAST_M   = wlast;
   assign WVALID_M  = wvalid;
   assign BREADY_M  = bready;

   logic unused_ok;
   assign unused_ok = ^{RID_M, BID_M, RRESP_M, BRESP_M};
endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl against a stalling AXI slave model with a word memory.
module tb_dma_ctrl;
   logic                      clk, rst;
   logic [31:0]               DMASRC, DMADST, DMALEN;
   logic                      DMAEN, tmp_DMAEN;
   logic                      DMA_INTR, DMA_BUSY, DMA_ERR;
   logic [`AXI_ID_BITS-1:0]   ARID_M, AWID_M, RID_M, BID_M;
   logic [31:0]               ARADDR_M, AWADDR_M, RDATA_M, WDATA_M;
   logic [`AXI_LEN_BITS-1:0]  ARLEN_M, AWLEN_M;
   logic [`AXI_SIZE_BITS-1:0] ARSIZE_M, AWSIZE_M;
   logic [1:0]                ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
   logic                      ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
   logic                      AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M;
   logic [`AXI_STRB_BITS-1:0] WSTRB_M;
   logic                      BVALID_M, BREADY_M;

   dma_ctrl #(.MAX_BURST(16), .DMA_ID(0)) dut (
      .clk(clk), .rst(rst), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
      .DMAEN(DMAEN), .tmp_DMAEN(tmp_DMAEN), .DMA_INTR(DMA_INTR), .DMA_BUSY(DMA_BUSY),
      .DMA_ERR(DMA_ERR), .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
      .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M),
      .ARREADY_M(ARREADY_M), .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
      .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .AWID_M(AWID_M),
      .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
      .BREADY_M(BREADY_M)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // slave memory and transaction logs
   logic [31:0] mem [logic [31:0]];
   logic [31:0] ar_addr_log[$], ar_len_log[$], aw_addr_log[$], aw_len_log[$], wlast_log[$];
   logic [31:0] rd_addr_q[$], rd_len_q[$];
   int          b_count, stable_bad, max_stall, bresp_err_next;
   int          n_vec, n_bad;

   function automatic logic [31:0] pat(input int i);
      return 32'hA5A5_0000 + 32'(i);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic stall();
      repeat ($urandom_range(0, max_stall)) @(negedge clk);
   endtask

   task automatic init_src(input logic [31:0] s, input int n);
      mem.delete();
      for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = pat(i);
   endtask

   task automatic clear_logs();
      ar_addr_log.delete(); ar_len_log.delete();
      aw_addr_log.delete(); aw_len_log.delete(); wlast_log.delete();
      b_count = 0;
      stable_bad = 0;
   endtask

   function automatic int mem_bad(input logic [31:0] d, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (!mem.exists(d + 32'(4 * i))) bad++;
         else if (mem[d + 32'(4 * i)] !== pat(i)) bad++;
      end
      return bad;
   endfunction

   // AR channel slave
   initial begin
      logic [31:0] a, l;
      ARREADY_M = 1'b0;
      forever begin
         @(negedge clk);
         if (ARVALID_M === 1'b1) begin
            a = ARADDR_M;
            l = 32'(ARLEN_M);
            repeat ($urandom_range(0, max_stall)) begin
               @(negedge clk);
               if (ARVALID_M !== 1'b1 || ARADDR_M !== a || 32'(ARLEN_M) !== l) stable_bad++;
            end
            ARREADY_M = 1'b1;
            @(negedge clk);
            ARREADY_M = 1'b0;
            ar_addr_log.push_back(a); ar_len_log.push_back(l);
            rd_addr_q.push_back(a);   rd_len_q.push_back(l);
         end
      end
   end

   // R channel slave
   initial begin
      logic [31:0] a, l, k;
      RVALID_M = 1'b0; RLAST_M = 1'b0; RDATA_M = '0; RRESP_M = 2'b00; RID_M = '0;
      forever begin
         @(negedge clk);
         if (rd_addr_q.size() > 0) begin
            a = rd_addr_q.pop_front();
            l = rd_len_q.pop_front();
            for (int i = 0; i <= int'(l); i++) begin
               RVALID_M = 1'b0;
               stall();
               k = a + 32'(4 * i);
               RVALID_M = 1'b1;
               RDATA_M  = mem.exists(k) ? mem[k] : 32'h0;
               RLAST_M  = (i == int'(l));
               while (RREADY_M !== 1'b1) @(negedge clk);
               @(negedge clk);
            end
            RVALID_M = 1'b0;
            RLAST_M  = 1'b0;
         end
      end
   end

   // AW, W and B channel slave
   initial begin
      logic [31:0] a, l, d;
      int          first_last;
      AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0; BRESP_M = 2'b00; BID_M = '0;
      forever begin
         @(negedge clk);
         if (AWVALID_M === 1'b1) begin
            a = AWADDR_M;
            l = 32'(AWLEN_M);
            repeat ($urandom_range(0, max_stall)) begin
               @(negedge clk);
               if (AWVALID_M !== 1'b1 || AWADDR_M !== a || 32'(AWLEN_M) !== l) stable_bad++;
            end
            AWREADY_M = 1'b1;
            @(negedge clk);
            AWREADY_M = 1'b0;
            aw_addr_log.push_back(a); aw_len_log.push_back(l);
            first_last = 0;
            for (int i = 0; i <= int'(l); i++) begin
               while (WVALID_M !== 1'b1) @(negedge clk);
               d = WDATA_M;
               repeat ($urandom_range(0, max_stall)) begin
                  @(negedge clk);
                  if (WVALID_M !== 1'b1 || WDATA_M !== d) stable_bad++;
               end
               WREADY_M = 1'b1;
               mem[a + 32'(4 * i)] = WDATA_M;
               if (WLAST_M === 1'b1 && first_last == 0) first_last = i + 1;
               @(negedge clk);
               WREADY_M = 1'b0;
            end
            wlast_log.push_back(32'(first_last));
            stall();
            BVALID_M = 1'b1;
            BRESP_M  = (bresp_err_next != 0) ? 2'b10 : 2'b00;
            bresp_err_next = 0;
            while (BREADY_M !== 1'b1) @(negedge clk);
            @(negedge clk);
            BVALID_M = 1'b0;
            BRESP_M  = 2'b00;
            b_count++;
         end
      end
   end

   // driver tasks
   task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
      DMASRC = s; DMADST = d; DMALEN = n;
      DMAEN = 1'b1; tmp_DMAEN = 1'b1;
      @(negedge clk);
      tmp_DMAEN = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(DMA_INTR === 1'b1 || DMA_BUSY === 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n >= 3000), 32'd0);
   endtask

   task automatic stop_and_check(input string tag);
      DMAEN = 1'b0;
      @(negedge clk);
      check({tag, "_intr_clear"}, 32'(DMA_INTR), 32'd0);
      check({tag, "_busy_clear"}, 32'(DMA_BUSY), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_ar[3], exp_aw[3], exp_len[3], exp_wl[3];
      int n, intr_seen;
      n_vec = 0; n_bad = 0; max_stall = 0; bresp_err_next = 0;
      rst = 1'b0; DMAEN = 1'b0; tmp_DMAEN = 1'b0;
      DMASRC = '0; DMADST = '0; DMALEN = '0;
      clear_logs();
      repeat (3) @(negedge clk);
      check("rst_arvalid", 32'(ARVALID_M), 32'd0);
      check("rst_rready",  32'(RREADY_M),  32'd0);
      check("rst_awvalid", 32'(AWVALID_M), 32'd0);
      check("rst_wvalid",  32'(WVALID_M),  32'd0);
      check("rst_bready",  32'(BREADY_M),  32'd0);
      check("rst_intr",    32'(DMA_INTR),  32'd0);
      check("rst_busy",    32'(DMA_BUSY),  32'd0);
      check("rst_err",     32'(DMA_ERR),   32'd0);
      rst = 1'b1;
      @(negedge clk);

      // single word, zero wait
      clear_logs(); init_src(32'h1000, 1);
      start(32'h1000, 32'h2000, 32'd1);
      check("t1_ar_latency", 32'(ARVALID_M), 32'd1);
      check("t1_arsize",     32'(ARSIZE_M),  32'd2);
      check("t1_arburst",    32'(ARBURST_M), 32'd1);
      wait_done("t1");
      check("t1_intr",     32'(DMA_INTR), 32'd1);
      check("t1_b_before", 32'(b_count), 32'd1);
      check("t1_ar_n",     32'(ar_addr_log.size()), 32'd1);
      check("t1_araddr",   ar_addr_log[0], 32'h1000);
      check("t1_arlen",    ar_len_log[0], 32'd0);
      check("t1_awaddr",   aw_addr_log[0], 32'h2000);
      check("t1_awlen",    aw_len_log[0], 32'd0);
      check("t1_data",     32'(mem_bad(32'h2000, 1)), 32'd0);
      stop_and_check("t1");

      // 40 words: bursts of 16/16/8
      clear_logs(); init_src(32'h1000, 40);
      exp_ar  = '{32'h1000, 32'h1040, 32'h1080};
      exp_aw  = '{32'h2000, 32'h2040, 32'h2080};
      exp_len = '{32'd15, 32'd15, 32'd7};
      exp_wl  = '{32'd16, 32'd16, 32'd8};
      start(32'h1000, 32'h2000, 32'd40);
      wait_done("t2");
      check("t2_ar_n", 32'(ar_addr_log.size()), 32'd3);
      check("t2_aw_n", 32'(aw_addr_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_araddr%0d", i), ar_addr_log[i], exp_ar[i]);
         check($sformatf("t2_arlen%0d", i),  ar_len_log[i],  exp_len[i]);
         check($sformatf("t2_awaddr%0d", i), aw_addr_log[i], exp_aw[i]);
         check($sformatf("t2_awlen%0d", i),  aw_len_log[i],  exp_len[i]);
         check($sformatf("t2_wlast%0d", i),  wlast_log[i],   exp_wl[i]);
      end
      check("t2_data", 32'(mem_bad(32'h2000, 40)), 32'd0);
      check("t2_intr", 32'(DMA_INTR), 32'd1);
      stop_and_check("t2");

      // random stalls, 20 words
      clear_logs(); init_src(32'h1000, 20); max_stall = 5;
      start(32'h1000, 32'h2000, 32'd20);
      wait_done("t3");
      check("t3_ar_n",   32'(ar_addr_log.size()), 32'd2);
      check("t3_arlen1", ar_len_log[1], 32'd3);
      check("t3_wlast1", wlast_log[1], 32'd4);
      check("t3_data",   32'(mem_bad(32'h2000, 20)), 32'd0);
      check("t3_stable", 32'(stable_bad), 32'd0);
      stop_and_check("t3");

      // abort during the first read burst of three
      clear_logs(); init_src(32'h1000, 40); max_stall = 2;
      start(32'h1000, 32'h2000, 32'd40);
      n = 0;
      while (RREADY_M !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("t4_rdata_to", 32'(n >= 200), 32'd0);
      repeat (2) @(negedge clk);
      DMAEN = 1'b0;
      n = 0; intr_seen = 0;
      while (DMA_BUSY === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (DMA_INTR === 1'b1) intr_seen = 1;
      end
      check("t4_idle_to", 32'(n >= 3000), 32'd0);
      repeat (10) @(negedge clk);
      check("t4_ar_n",     32'(ar_addr_log.size()), 32'd1);
      check("t4_aw_n",     32'(aw_addr_log.size()), 32'd1);
      check("t4_wlast",    wlast_log[0], 32'd16);
      check("t4_intr",     32'(intr_seen), 32'd0);
      check("t4_data",     32'(mem_bad(32'h2000, 16)), 32'd0);
      check("t4_no_extra", 32'(mem.exists(32'h2040)), 32'd0);

      // zero length
      clear_logs(); max_stall = 0;
      start(32'h1000, 32'h2000, 32'd0);
      check("t5_intr",    32'(DMA_INTR), 32'd1);
      check("t5_arvalid", 32'(ARVALID_M), 32'd0);
      repeat (4) @(negedge clk);
      check("t5_ar_n",   32'(ar_addr_log.size()), 32'd0);
      check("t5_intr_h", 32'(DMA_INTR), 32'd1);
      stop_and_check("t5");

`ifdef DMA_RESP_CHECK_EN
      // SLVERR on the first write response of two bursts
      clear_logs(); init_src(32'h1000, 32); bresp_err_next = 1;
      start(32'h1000, 32'h2000, 32'd32);
      wait_done("t7");
      repeat (4) @(negedge clk);
      check("t7_err",  32'(DMA_ERR), 32'd1);
      check("t7_intr", 32'(DMA_INTR), 32'd1);
      check("t7_ar_n", 32'(ar_addr_log.size()), 32'd1);
      stop_and_check("t7");
      start(32'h1000, 32'h2000, 32'd0);
      check("t7_err_clr", 32'(DMA_ERR), 32'd0);
      stop_and_check("t7b");
`endif

      // asynchronous reset during the write burst
      clear_logs(); init_src(32'h1000, 16); max_stall = 3;
      start(32'h1000, 32'h2000, 32'd16);
      n = 0;
      while (WVALID_M !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      check("t6_wdata_to", 32'(n >= 500), 32'd0);
      rst = 1'b0;
      #1;
      check("t6_wvalid",  32'(WVALID_M),  32'd0);
      check("t6_arvalid", 32'(ARVALID_M), 32'd0);
      check("t6_awvalid", 32'(AWVALID_M), 32'd0);
      check("t6_rready",  32'(RREADY_M),  32'd0);
      check("t6_bready",  32'(BREADY_M),  32'd0);
      check("t6_busy",    32'(DMA_BUSY),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
